// File: rtl/matrix_op_engine.sv
// Banked matrix engine: LOAD/STORE streaming plus elementwise ALU ops and
// transpose, one element per cycle, driven by a single-instruction FSM.
module matrix_op_engine #(
  parameter int DIM   = 8,
  parameter int EW    = 8,
  parameter int NBANK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [EW-1:0] data_in,
  input  logic          data_in_valid,
  output logic          data_in_ready,
  output logic [EW-1:0] data_out,
  output logic          data_out_valid,
  input  logic          data_out_ready,
  output logic          busy,
  output logic          err
);
  // state  | meaning
  // IDLE   | waiting for an instruction
  // LOAD   | writing streamed data_in beats into bank dst
  // EXEC   | one element per cycle of an ALU op or transpose
  // STORE  | streaming bank srca out through data_out
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_STORE} state_t;

  localparam int DD = DIM * DIM;
  localparam int KW = $clog2(DD);
  localparam int RW = $clog2(DIM);
  localparam int BW = $clog2(NBANK);
  localparam logic [3:0]    NB      = 4'(NBANK);
  localparam logic [RW-1:0] RC_LAST = RW'(DIM - 1);
  localparam logic [KW-1:0] K0      = '0;

  state_t          state;
  logic [EW-1:0]   mem [NBANK][DD];
  logic [3:0]      op;
  logic [BW-1:0]   dst, srca, srcb;
  logic [2:0]      imm;
  logic [RW-1:0]   row, col;

  logic [3:0]      i_op;
  logic [2:0]      i_dst, i_srca, i_srcb;
  logic            use_d, use_a, use_b, reject;
  logic [KW-1:0]   k, k_t, k_wr;
  logic            col_last, last;
  logic [EW-1:0]   a_val, b_val, res;

  assign i_op   = instr[15:12];
  assign i_dst  = instr[11:9];
  assign i_srca = instr[8:6];
  assign i_srcb = instr[5:3];

  assign busy          = (state != S_IDLE);
  assign instr_ready   = !busy;
  assign data_in_ready = (state == S_LOAD);

  assign k        = KW'(row) * KW'(DIM) + KW'(col);
  assign k_t      = KW'(col) * KW'(DIM) + KW'(row);
  assign k_wr     = (op == 4'd9) ? k_t : k;
  assign col_last = (col == RC_LAST);
  assign last     = col_last && (row == RC_LAST);

  always_comb begin
    use_d = 1'b0;
    use_a = 1'b0;
    use_b = 1'b0;
    case (i_op)
      4'd1:                   use_d = 1'b1;
      4'd2:                   use_a = 1'b1;
      4'd3, 4'd4, 4'd8:       begin use_d = 1'b1; use_a = 1'b1; use_b = 1'b1; end
      4'd5, 4'd6, 4'd7, 4'd9: begin use_d = 1'b1; use_a = 1'b1; end
      default: ;
    endcase
    reject = (i_op > 4'd9)
          || (use_d && ({1'b0, i_dst}  >= NB))
          || (use_a && ({1'b0, i_srca} >= NB))
          || (use_b && ({1'b0, i_srcb} >= NB))
          || (i_op == 4'd9 && i_dst == i_srca);
  end

  // Operands are read combinationally so dst may alias a source.
  assign a_val = mem[srca][k];
  assign b_val = mem[srcb][k];

  always_comb begin
    case (op)
      4'd3:    res = a_val + b_val;
      4'd4:    res = a_val - b_val;
      4'd5:    res = a_val << imm;
      4'd6:    res = a_val >> imm;
      4'd8:    res = a_val * b_val;
      default: res = a_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      op             <= '0;
      dst            <= '0;
      srca           <= '0;
      srcb           <= '0;
      imm            <= '0;
      row            <= '0;
      col            <= '0;
      err            <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      for (int b = 0; b < NBANK; b++)
        for (int i = 0; i < DD; i++)
          mem[b][i] <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            if (reject) begin
              err <= 1'b1;
            end else begin
              op   <= i_op;
              dst  <= i_dst[BW-1:0];
              srca <= i_srca[BW-1:0];
              srcb <= i_srcb[BW-1:0];
              imm  <= instr[2:0];
              row  <= '0;
              col  <= '0;
              case (i_op)
                4'd0: ;
                4'd1: state <= S_LOAD;
                4'd2: begin
                  state          <= S_STORE;
                  data_out       <= mem[i_srca[BW-1:0]][K0];
                  data_out_valid <= 1'b1;
                end
                default: state <= S_EXEC;
              endcase
            end
          end
        end
        S_LOAD: begin
          if (data_in_valid) begin
            mem[dst][k] <= data_in;
            col <= col_last ? '0 : col + 1'b1;
            if (col_last) row <= row + 1'b1;
            if (last) state <= S_IDLE;
          end
        end
        S_EXEC: begin
          mem[dst][k_wr] <= res;
          col <= col_last ? '0 : col + 1'b1;
          if (col_last) row <= row + 1'b1;
          if (last) state <= S_IDLE;
        end
        S_STORE: begin
          if (data_out_ready) begin
            if (last) begin
              data_out_valid <= 1'b0;
              state          <= S_IDLE;
            end else begin
              data_out <= mem[srca][k + 1'b1];
            end
            col <= col_last ? '0 : col + 1'b1;
            if (col_last) row <= row + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_op_engine.sv
// Directed bench for matrix_op_engine at DIM=2, EW=8, NBANK=4.
module tb_matrix_op_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  data_in = '0;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        data_out_ready = 1'b0;
  logic        busy;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  matrix_op_engine #(.DIM(2), .EW(8), .NBANK(4)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int d, input int a, input int b, input int im);
    return {op[3:0], d[2:0], a[2:0], b[2:0], im[2:0]};
  endfunction

  // Leaves the caller at the negedge of the cycle after the accept cycle.
  task automatic send(input logic [15:0] w);
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // vals packs elements k=0..3 as {k0,k1,k2,k3}; one idle gap after beat 1.
  task automatic load(input int bank, input logic [31:0] vals);
    send(mk(1, bank, 0, 0, 0));
    chk("load_din_ready", data_in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      data_in       = vals[31-8*i -: 8];
      data_in_valid = 1'b1;
      @(negedge clk);
      if (i == 1) begin
        data_in_valid = 1'b0;
        data_in       = 8'hEE;
        @(negedge clk);
      end
    end
    data_in_valid = 1'b0;
    chk("load_done_busy", busy, 0);
  endtask

  task automatic store(input int bank, input logic [31:0] exp, input string tag);
    int  n;
    logic tog;
    n   = 0;
    tog = 1'b0;
    send(mk(2, 0, bank, 0, 0));
    for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
      data_out_ready = tog;
      if (data_out_valid && tog) begin
        chk($sformatf("%s_k%0d", tag, n), data_out, exp[31-8*n -: 8]);
        n++;
      end
      tog = ~tog;
      @(negedge clk);
    end
    data_out_ready = 1'b0;
    chk({tag, "_beats"}, n, 4);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_valid"}, data_out_valid, 0);
  endtask

  task automatic exec(input logic [15:0] w, input string tag);
    int cnt;
    cnt = 0;
    send(w);
    chk({tag, "_no_err"}, err, 0);
    repeat (8) begin
      if (busy) cnt++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, cnt, 4);
  endtask

  task automatic reject(input logic [15:0] w, input string tag);
    send(w);
    chk({tag, "_err"}, err, 1);
    chk({tag, "_busy"}, busy, 0);
    @(negedge clk);
    chk({tag, "_err_clear"}, err, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_dov", data_out_valid, 0);
    chk("rst_din_ready", data_in_ready, 0);
    chk("rst_dout", data_out, 0);
    reset = 1'b1;

    send(mk(0, 0, 0, 0, 0));
    chk("nop_busy", busy, 0);
    chk("nop_err", err, 0);

    load(0, 32'h01020304);
    store(0, 32'h01020304, "st_basic");

    load(0, {8'd250, 8'd1, 8'd2, 8'd3});
    load(1, {8'd10, 8'd1, 8'd1, 8'd1});
    exec(mk(3, 2, 0, 1, 0), "add");
    store(2, {8'd4, 8'd2, 8'd3, 8'd4}, "st_add");
    exec(mk(4, 3, 0, 1, 0), "sub");
    store(3, {8'd240, 8'd0, 8'd1, 8'd2}, "st_sub");

    load(0, 32'h01020304);
    exec(mk(9, 1, 0, 0, 0), "tr");
    store(1, 32'h01030204, "st_tr");
    reject(mk(9, 0, 0, 0, 0), "tr_self");
    store(0, 32'h01020304, "st_tr_self");

    reject(mk(12, 0, 0, 1, 0), "op12");
    reject(mk(3, 2, 0, 5, 0), "srcb5");
    store(0, 32'h01020304, "st_rj_b0");
    store(1, 32'h01030204, "st_rj_b1");
    store(2, {8'd4, 8'd2, 8'd3, 8'd4}, "st_rj_b2");
    store(3, {8'd240, 8'd0, 8'd1, 8'd2}, "st_rj_b3");

    load(0, 32'h8140FF01);
    exec(mk(5, 0, 0, 0, 1), "shl");
    store(0, 32'h0280FE02, "st_shl");
    exec(mk(8, 1, 0, 0, 0), "mul");
    store(1, 32'h04000404, "st_mul");
    exec(mk(6, 2, 0, 0, 3), "shr");
    store(2, 32'h00101F00, "st_shr");

    send(mk(1, 3, 0, 0, 0));
    data_in       = 8'd9;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in = 8'd8;
    reset   = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", instr_ready, 1);
    reset         = 1'b1;
    data_in_valid = 1'b0;
    @(negedge clk);
    chk("rst_after_ready", instr_ready, 1);
    store(3, 32'h00000000, "st_rst_b3");
    store(0, 32'h00000000, "st_rst_b0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
